// File: rtl/pcie_cpld_pkg.sv
// Shared types and decode helpers for the PCIe completion-with-data generator.
package pcie_cpld_pkg;

  localparam logic [6:0] FMT_TYPE_CPLD = 7'b1001010;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA
  } cpld_state_e;

  typedef struct packed {
    logic [15:0] requester_id;
    logic [7:0]  tag;
    logic [2:0]  tc;
    logic [1:0]  attr;
    logic [6:0]  addr_lo;
    logic [3:0]  first_be;
  } cpld_ctx_t;

  // Bytes covered from the first enabled byte to the last enabled byte of one DW.
  function automatic logic [11:0] calc_byte_count(input logic [3:0] be);
    logic [11:0] bc;
    bc = 12'd1;
    casez (be)
      4'b1??1:                   bc = 12'd4;
      4'b01?1, 4'b1?10:          bc = 12'd3;
      4'b0011, 4'b0110, 4'b1100: bc = 12'd2;
      default:                   bc = 12'd1;
    endcase
    return bc;
  endfunction

  function automatic logic [6:0] calc_lower_addr(input logic [6:0] addr_lo, input logic [3:0] be);
    logic [1:0] idx;
    if (be[0])      idx = 2'd0;
    else if (be[1]) idx = 2'd1;
    else if (be[2]) idx = 2'd2;
    else if (be[3]) idx = 2'd3;
    else            idx = 2'd0;
    return (addr_lo & 7'h7C) | {5'b00000, idx};
  endfunction

endpackage

// File: rtl/pcie_cpld_gen_if.sv
// Request-context, read-data and completion-stream signals of pcie_cpld_gen.
// CPLD_POISON_EN adds axi_cpld_err alongside the read data.
interface pcie_cpld_gen_if;

  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_requester_id;
  logic [7:0]  req_tag;
  logic [2:0]  req_tc;
  logic [1:0]  req_attr;
  logic [6:0]  req_addr_lo;
  logic [3:0]  req_first_be;

  logic        axi_cpld_valid;
  logic        axi_cpld_ready;
  logic [63:0] axi_cpld_data;
`ifdef CPLD_POISON_EN
  logic        axi_cpld_err;
`endif

  logic [63:0] s_axis_cc_tdata;
  logic [7:0]  s_axis_cc_tkeep;
  logic        s_axis_cc_tlast;
  logic        s_axis_cc_tvalid;
  logic        s_axis_cc_tready;

`ifdef CPLD_POISON_EN
  modport slave (
    input  req_valid, req_requester_id, req_tag, req_tc, req_attr, req_addr_lo, req_first_be,
    output req_ready,
    input  axi_cpld_valid, axi_cpld_data, axi_cpld_err,
    output axi_cpld_ready,
    output s_axis_cc_tdata, s_axis_cc_tkeep, s_axis_cc_tlast, s_axis_cc_tvalid,
    input  s_axis_cc_tready
  );
  modport master (
    output req_valid, req_requester_id, req_tag, req_tc, req_attr, req_addr_lo, req_first_be,
    input  req_ready,
    output axi_cpld_valid, axi_cpld_data, axi_cpld_err,
    input  axi_cpld_ready,
    input  s_axis_cc_tdata, s_axis_cc_tkeep, s_axis_cc_tlast, s_axis_cc_tvalid,
    output s_axis_cc_tready
  );
`else
  modport slave (
    input  req_valid, req_requester_id, req_tag, req_tc, req_attr, req_addr_lo, req_first_be,
    output req_ready,
    input  axi_cpld_valid, axi_cpld_data,
    output axi_cpld_ready,
    output s_axis_cc_tdata, s_axis_cc_tkeep, s_axis_cc_tlast, s_axis_cc_tvalid,
    input  s_axis_cc_tready
  );
  modport master (
    output req_valid, req_requester_id, req_tag, req_tc, req_attr, req_addr_lo, req_first_be,
    input  req_ready,
    output axi_cpld_valid, axi_cpld_data,
    input  axi_cpld_ready,
    input  s_axis_cc_tdata, s_axis_cc_tkeep, s_axis_cc_tlast, s_axis_cc_tvalid,
    output s_axis_cc_tready
  );
`endif

endinterface

// File: rtl/pcie_cpld_ctx_fifo.sv
// In-order show-ahead FIFO holding outstanding read-request contexts.
module pcie_cpld_ctx_fifo
  import pcie_cpld_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  cpld_ctx_t                push_data,
  input  logic                     pop,
  output cpld_ctx_t                head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  cpld_ctx_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count < CNT_W'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pcie_cpld_gen.sv
// Builds a 1-DW CplD TLP (header beat + data beat) per read-data word using queued request contexts.
// Define CPLD_POISON_EN to add axi_cpld_err, which sets the EP bit of the completion.
module pcie_cpld_gen
  import pcie_cpld_pkg::*;
#(
  parameter int unsigned CTX_DEPTH    = 8,
  parameter int unsigned C_DATA_WIDTH = 64
) (
  input  logic                       m_axi_aclk,
  input  logic                       m_axi_areset,
  input  logic [15:0]                completer_id,
  pcie_cpld_gen_if.slave             bus,
  output logic [$clog2(CTX_DEPTH):0] ctx_count
);

  localparam int unsigned CNT_W = $clog2(CTX_DEPTH) + 1;

  if (C_DATA_WIDTH != 64 || CTX_DEPTH < 2 || (CTX_DEPTH & (CTX_DEPTH - 1)) != 0) begin : g_param_check
    $error("pcie_cpld_gen: C_DATA_WIDTH must be 64 and CTX_DEPTH a power of 2 >= 2");
  end

  cpld_state_e      state;
  cpld_ctx_t        push_ctx;
  cpld_ctx_t        head;
  logic             push;
  logic             pop;
  logic             ep;
  logic [CNT_W-1:0] count_next;
  logic [31:0]      dw0;
  logic [31:0]      dw1;
  logic [31:0]      dw2;
  logic [31:0]      data_dw;
  logic [63:0]      data_beat;

  assign push       = bus.req_valid & bus.req_ready;
  assign pop        = bus.axi_cpld_valid & bus.axi_cpld_ready;
  assign count_next = ctx_count + CNT_W'(push) - CNT_W'(pop);

  assign push_ctx = '{requester_id: bus.req_requester_id,
                      tag:          bus.req_tag,
                      tc:           bus.req_tc,
                      attr:         bus.req_attr,
                      addr_lo:      bus.req_addr_lo,
                      first_be:     bus.req_first_be};

`ifdef CPLD_POISON_EN
  assign ep = bus.axi_cpld_err;
`else
  assign ep = 1'b0;
`endif

  // Completion fields are formed from the FIFO head in the cycle the data is accepted.
  assign dw0     = {1'b0, FMT_TYPE_CPLD, 1'b0, head.tc, 4'b0000, 1'b0, ep, head.attr, 2'b00, 10'd1};
  assign dw1     = {completer_id, 3'b000, 1'b0, calc_byte_count(head.first_be)};
  assign dw2     = {head.requester_id, head.tag, 1'b0, calc_lower_addr(head.addr_lo, head.first_be)};
  assign data_dw = head.addr_lo[2] ? bus.axi_cpld_data[63:32] : bus.axi_cpld_data[31:0];

  pcie_cpld_ctx_fifo #(.DEPTH(CTX_DEPTH)) u_ctx_fifo (
    .clk       (m_axi_aclk),
    .rst       (m_axi_areset),
    .push      (push),
    .push_data (push_ctx),
    .pop       (pop),
    .head      (head),
    .count     (ctx_count)
  );

  // Readies are registered from next-cycle state and count so they match their combinational definitions.
  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      state                <= IDLE;
      bus.req_ready        <= 1'b0;
      bus.axi_cpld_ready   <= 1'b0;
      bus.s_axis_cc_tvalid <= 1'b0;
      bus.s_axis_cc_tlast  <= 1'b0;
      bus.s_axis_cc_tdata  <= '0;
      bus.s_axis_cc_tkeep  <= '0;
      data_beat            <= '0;
    end else begin
      bus.req_ready      <= (count_next < CNT_W'(CTX_DEPTH));
      bus.axi_cpld_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            state                <= HDR;
            bus.s_axis_cc_tvalid <= 1'b1;
            bus.s_axis_cc_tlast  <= 1'b0;
            bus.s_axis_cc_tkeep  <= '1;
            bus.s_axis_cc_tdata  <= {dw1, dw0};
            data_beat            <= {data_dw, dw2};
          end else begin
            bus.axi_cpld_ready <= (count_next != '0);
          end
        end
        HDR: begin
          if (bus.s_axis_cc_tready) begin
            state               <= DATA;
            bus.s_axis_cc_tdata <= data_beat;
            bus.s_axis_cc_tlast <= 1'b1;
          end
        end
        DATA: begin
          if (bus.s_axis_cc_tready) begin
            state                <= IDLE;
            bus.s_axis_cc_tvalid <= 1'b0;
            bus.s_axis_cc_tlast  <= 1'b0;
            bus.s_axis_cc_tdata  <= '0;
            bus.s_axis_cc_tkeep  <= '0;
            bus.axi_cpld_ready   <= (count_next != '0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pcie_cpld_gen.sv
// Directed self-checking bench for pcie_cpld_gen with hand-computed completion beats.
module tb_pcie_cpld_gen;

  logic        clk = 1'b0;
  logic        areset;
  logic [15:0] completer_id;
  logic [3:0]  ctx_count;
  int          checks = 0;
  int          errors = 0;

  logic [63:0] b0, b1;
  int          first_at;
  logic [3:0]  be_tab [8];
  int          bc_tab [8];
  int          la_tab [8];

  pcie_cpld_gen_if bus();

  pcie_cpld_gen #(.CTX_DEPTH(8), .C_DATA_WIDTH(64)) dut (
    .m_axi_aclk   (clk),
    .m_axi_areset (areset),
    .completer_id (completer_id),
    .bus          (bus),
    .ctx_count    (ctx_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic push_ctx(input logic [15:0] rid, input logic [7:0] tag, input logic [2:0] tc,
                          input logic [1:0] attr, input logic [6:0] addr, input logic [3:0] be);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    bus.req_requester_id = rid;
    bus.req_tag          = tag;
    bus.req_tc           = tc;
    bus.req_attr         = attr;
    bus.req_addr_lo      = addr;
    bus.req_first_be     = be;
    bus.req_valid        = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.req_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("push_accept", 64'(ok), 64'd1);
  endtask

  task automatic send_data(input logic [63:0] d);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    bus.axi_cpld_data  = d;
    bus.axi_cpld_valid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.axi_cpld_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    bus.axi_cpld_valid = 1'b0;
    chk("data_accept", 64'(ok), 64'd1);
  endtask

  // Call right after a posedge; captures both beats of one TLP with tready held high.
  task automatic collect_tlp(output logic [63:0] h, output logic [63:0] d, output int first);
    int nb;
    nb = 0; h = '0; d = '0; first = -1;
    bus.s_axis_cc_tready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.s_axis_cc_tvalid) begin
        if (nb == 0) begin
          h = bus.s_axis_cc_tdata; first = n;
          chk("hdr_tkeep", 64'(bus.s_axis_cc_tkeep), 64'hFF);
          chk("hdr_tlast", 64'(bus.s_axis_cc_tlast), 64'd0);
        end else begin
          d = bus.s_axis_cc_tdata;
          chk("data_tkeep", 64'(bus.s_axis_cc_tkeep), 64'hFF);
          chk("data_tlast", 64'(bus.s_axis_cc_tlast), 64'd1);
        end
        nb++;
        if (nb == 2) break;
      end
    end
    chk("tlp_beats", 64'(nb), 64'd2);
    @(posedge clk); #1;
    bus.s_axis_cc_tready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    be_tab = '{4'b1001, 4'b0101, 4'b1010, 4'b0011, 4'b1100, 4'b0001, 4'b0000, 4'b1000};
    bc_tab = '{4, 3, 3, 2, 2, 1, 1, 1};
    la_tab = '{0, 0, 1, 0, 2, 0, 0, 3};

    areset               = 1'b1;
    completer_id         = 16'h0200;
    bus.req_valid        = 1'b0;
    bus.req_requester_id = '0;
    bus.req_tag          = '0;
    bus.req_tc           = '0;
    bus.req_attr         = '0;
    bus.req_addr_lo      = '0;
    bus.req_first_be     = '0;
    bus.axi_cpld_valid   = 1'b0;
    bus.axi_cpld_data    = '0;
    bus.s_axis_cc_tready = 1'b0;
`ifdef CPLD_POISON_EN
    bus.axi_cpld_err     = 1'b0;
`endif

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctx_count",  64'(ctx_count), 64'd0);
    chk("rst_req_ready",  64'(bus.req_ready), 64'd0);
    chk("rst_cpld_ready", 64'(bus.axi_cpld_ready), 64'd0);
    chk("rst_tvalid",     64'(bus.s_axis_cc_tvalid), 64'd0);
    chk("rst_tlast",      64'(bus.s_axis_cc_tlast), 64'd0);
    chk("rst_tdata",      bus.s_axis_cc_tdata, 64'd0);
    chk("rst_tkeep",      64'(bus.s_axis_cc_tkeep), 64'd0);
    @(posedge clk); #1;
    areset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_req_ready", 64'(bus.req_ready), 64'd1);

    // Basic completion
    push_ctx(16'h0100, 8'h05, 3'd0, 2'd0, 7'h04, 4'hF);
    send_data(64'hAABBCCDD_11223344);
    collect_tlp(b0, b1, first_at);
    chk("basic_hdr",     b0, 64'h02000004_4A000001);
    chk("basic_data",    b1, 64'hAABBCCDD_01000504);
    chk("basic_latency", 64'(first_at), 64'd0);
    chk("basic_count",   64'(ctx_count), 64'd0);

    // Partial byte enables, nonzero tc/attr
    push_ctx(16'h1234, 8'h22, 3'd2, 2'd1, 7'h10, 4'b0110);
    send_data(64'h55667788_99AABBCC);
    collect_tlp(b0, b1, first_at);
    chk("partial_hdr",  b0, 64'h02000002_4A201001);
    chk("partial_data", b1, 64'h99AABBCC_12342211);

    // Orphan data with empty FIFO
    @(posedge clk); #1;
    bus.axi_cpld_data  = 64'h1111_2222_3333_4444;
    bus.axi_cpld_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("orphan_cpld_ready", 64'(bus.axi_cpld_ready), 64'd0);
      chk("orphan_tvalid",     64'(bus.s_axis_cc_tvalid), 64'd0);
    end
    bus.axi_cpld_valid = 1'b0;

    // Fill FIFO, then drain checking byte_count / lower_addr decode
    for (int i = 0; i < 8; i++) push_ctx(16'h0300, 8'(i), 3'd0, 2'd0, 7'h00, be_tab[i]);
    @(negedge clk);
    chk("full_req_ready", 64'(bus.req_ready), 64'd0);
    chk("full_count",     64'(ctx_count), 64'd8);
    bus.req_tag   = 8'hFF;
    bus.req_valid = 1'b1;
    @(negedge clk);
    chk("full_no_push", 64'(ctx_count), 64'd8);
    bus.req_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send_data({32'hF0000000 | 32'(i), 32'h00001000 | 32'(i)});
      if (i == 0) begin
        @(negedge clk);
        chk("full_pop_req_ready", 64'(bus.req_ready), 64'd1);
        chk("full_pop_count",     64'(ctx_count), 64'd7);
        @(posedge clk); #1;
      end
      collect_tlp(b0, b1, first_at);
      chk("drain_hdr",  b0, {16'h0200, 4'h0, 12'(bc_tab[i]), 32'h4A000001});
      chk("drain_data", b1, {32'h00001000 | 32'(i), 16'h0300, 8'(i), 1'b0, 7'(la_tab[i])});
    end

    // Backpressure in HDR
    push_ctx(16'h0100, 8'h07, 3'd0, 2'd0, 7'h04, 4'hF);
    push_ctx(16'h0101, 8'h08, 3'd0, 2'd0, 7'h00, 4'b0001);
    send_data(64'h01234567_89ABCDEF);
    bus.axi_cpld_data  = 64'hDEADBEEF_CAFEF00D;
    bus.axi_cpld_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_tdata",      bus.s_axis_cc_tdata, 64'h02000004_4A000001);
      chk("bp_tvalid",     64'(bus.s_axis_cc_tvalid), 64'd1);
      chk("bp_tlast",      64'(bus.s_axis_cc_tlast), 64'd0);
      chk("bp_cpld_ready", 64'(bus.axi_cpld_ready), 64'd0);
      chk("bp_count",      64'(ctx_count), 64'd1);
    end
    bus.axi_cpld_valid = 1'b0;
    @(posedge clk); #1;
    collect_tlp(b0, b1, first_at);
    chk("bp_hdr",        b0, 64'h02000004_4A000001);
    chk("bp_data",       b1, 64'h01234567_01000704);
    chk("bp_count_after", 64'(ctx_count), 64'd1);
    send_data(64'hDEADBEEF_CAFEF00D);
    collect_tlp(b0, b1, first_at);
    chk("bp2_hdr",  b0, 64'h02000001_4A000001);
    chk("bp2_data", b1, 64'hCAFEF00D_01010800);

    // Reset while in DATA
    push_ctx(16'h0400, 8'h11, 3'd0, 2'd0, 7'h00, 4'hF);
    push_ctx(16'h0401, 8'h12, 3'd0, 2'd0, 7'h00, 4'hF);
    send_data(64'h12345678_9ABCDEF0);
    bus.s_axis_cc_tready = 1'b1;
    @(posedge clk); #1;
    bus.s_axis_cc_tready = 1'b0;
    @(negedge clk);
    chk("mid_tlast",  64'(bus.s_axis_cc_tlast), 64'd1);
    chk("mid_tvalid", 64'(bus.s_axis_cc_tvalid), 64'd1);
    @(posedge clk); #1;
    areset = 1'b1;
    @(posedge clk); #1;
    areset = 1'b0;
    @(negedge clk);
    chk("rst_mid_tvalid", 64'(bus.s_axis_cc_tvalid), 64'd0);
    chk("rst_mid_count",  64'(ctx_count), 64'd0);
    chk("rst_mid_tlast",  64'(bus.s_axis_cc_tlast), 64'd0);
    chk("rst_mid_tdata",  bus.s_axis_cc_tdata, 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_req_ready", 64'(bus.req_ready), 64'd1);
    push_ctx(16'h0100, 8'h33, 3'd0, 2'd0, 7'h04, 4'hF);
    send_data(64'hAABBCCDD_11223344);
    collect_tlp(b0, b1, first_at);
    chk("post_rst_hdr",   b0, 64'h02000004_4A000001);
    chk("post_rst_data",  b1, 64'hAABBCCDD_01003304);
    chk("post_rst_count", 64'(ctx_count), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pcie_cpld_gen.md
PCIE_CPLD_GEN -- requirements
Module: pcie_cpld_gen

Interface
REQ-001 SHALL have parameter CTX_DEPTH, default 8, giving outstanding-read context entries; power of 2, minimum 2.
REQ-002 SHALL have parameter C_DATA_WIDTH, default 64, giving the completion stream width; only 64 is supported.
REQ-003 Ports, clock and reset first:
- m_axi_aclk  in  1  single clock.
- m_axi_areset  in  1  reset, synchronous, active-high.
- completer_id  in  16  bus/dev/func inserted in DW1.
- req_valid  in  1  read-request context valid.
- req_ready  out  1  context accepted.
- req_requester_id  in  16  requester ID.
- req_tag  in  8  request tag.
- req_tc  in  3  traffic class.
- req_attr  in  2  attributes.
- req_addr_lo  in  7  request address bits [6:0].
- req_first_be  in  4  first-DW byte enables.
- axi_cpld_valid  in  1  read data valid.
- axi_cpld_ready  out  1  read data accepted.
- axi_cpld_data  in  64  read data.
- s_axis_cc_tdata  out  64  completion TLP data.
- s_axis_cc_tkeep  out  8  byte keep.
- s_axis_cc_tlast  out  1  last beat.
- s_axis_cc_tvalid  out  1  beat valid.
- s_axis_cc_tready  in  1  beat accepted.
- ctx_count  out  $clog2(CTX_DEPTH)+1  contexts held.

Function
REQ-004 SHALL store each accepted context (req_valid&req_ready) in an in-order FIFO of CTX_DEPTH entries.
REQ-005 SHALL drive req_ready=1 iff ctx_count<CTX_DEPTH; a pop in the same cycle SHALL NOT admit a push when full.
REQ-006 SHALL drive axi_cpld_ready=1 iff state==IDLE and ctx_count!=0; data SHALL never be accepted without a context.
REQ-007 States SHALL be IDLE, HDR, DATA.
- IDLE->HDR on axi_cpld_valid&axi_cpld_ready; the FIFO head is popped and the header and data DW are registered in the same cycle.
- HDR->DATA on tvalid&tready.
- DATA->IDLE on tvalid&tready.
REQ-008 s_axis_cc_tvalid SHALL be 1 in HDR and DATA; tdata/tkeep/tlast SHALL hold stable while tvalid&!tready.
REQ-009 Data acceptance to first tvalid latency SHALL be 1 cycle; minimum spacing between completions SHALL be 3 cycles.
REQ-010 HDR beat SHALL have tdata={DW1,DW0}, tkeep=8'hFF, tlast=0, where:
- DW0={1'b0,7'b1001010,1'b0,tc,4'b0,td=0,ep,attr,2'b00,length=10'd1}.
- DW1={completer_id,3'b000,1'b0,byte_count[11:0]}.
REQ-011 DATA beat SHALL have tdata={data_dw,DW2}, tkeep=8'hFF, tlast=1, where:
- DW2={requester_id,tag,1'b0,lower_addr}.
- data_dw=axi_cpld_data[63:32] if req_addr_lo[2]=1, else axi_cpld_data[31:0].
REQ-012 byte_count SHALL be decoded from req_first_be:
- 4 for 1xx1.
- 3 for 01x1 and 1x10.
- 2 for 0011, 0110, 1100.
- 1 for single-bit BE and for 0000.
REQ-013 lower_addr SHALL be {req_addr_lo[6:2], index of lowest set bit of req_first_be}; for 0000 the index SHALL be 2'b00.
REQ-014 ctx_count SHALL increment on push, decrement on pop, and be unchanged on simultaneous push and pop.

Reset
REQ-015 While m_axi_areset=1, the block SHALL force state=IDLE, empty the FIFO, and drive ctx_count=0, req_ready=0, axi_cpld_ready=0, tvalid=0, tlast=0, tdata=0, tkeep=0.
REQ-016 Reset asserted mid-TLP SHALL drop the TLP and all contexts; req_ready SHALL return to 1 the first cycle after reset deasserts.

Configuration
REQ-017 Macro CPLD_POISON_EN SHALL add input axi_cpld_err (1 bit), sampled with the data; the registered value SHALL set the DW0 EP bit.
REQ-018 Without CPLD_POISON_EN, the port SHALL be absent and EP SHALL be 0.

Structure
REQ-019 Package pcie_cpld_pkg SHALL hold:
- the FMT_TYPE_CPLD constant.
- the state enum.
- the context struct (requester_id, tag, tc, attr, addr_lo, first_be).
- the byte_count and lower_addr decode functions.
REQ-020 The context FIFO SHALL be sub-module pcie_cpld_ctx_fifo (synchronous, show-ahead).

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Basic: context {rid=16'h0100, tag=8'h05, addr_lo=7'h04, be=4'hF}, data 64'hAABBCCDD_11223344 -> DW1 byte_count=4; DW2=32'h01000504; data_dw=32'hAABBCCDD; tlast on beat 2.
- Partial BE: be=4'b0110, addr_lo=7'h10 -> byte_count=2, lower_addr=7'h11, data_dw=low DW.
- Full FIFO: 8 contexts pushed, no data -> req_ready=0 and ctx_count=8; one data beat accepted -> req_ready=1 the next cycle.
- Backpressure: tready=0 for 5 cycles in HDR -> beat 0 held stable, no second data accepted; one completion emitted after release.
- Orphan data: axi_cpld_valid=1 with FIFO empty -> axi_cpld_ready=0, no TLP emitted.
- Reset in DATA: areset pulsed -> tvalid=0, ctx_count=0 the next cycle; a subsequent request completes normally.
